avg_readout_arbiter: RTL and testbench
======================================

Name: avg_readout_arbiter

Overview:
- Shares one ARM readout FIFO between NUM_CH averaging channels.
- Each channel raises ch_ready when its accumulated frame is complete and it is waiting for dout_enable.
- The arbiter grants channels round-robin, gives the winner its dout_enable, and routes that channel's dout/wrreq/aclr to the ARM FIFO.
- It detects frame completion (ARM FIFO full), then notifies the ARM and waits for its acknowledge before the next grant.

Parameters:
- NUM_CH, 2: number of averaging channels.
- DW, 10: sample width of dout / armfifo_data.
- TO_W, 16: width of the transfer watchdog counter.
- TIMEOUT, 20000: maximum cycles allowed in XFER before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits new grants; does not abort a grant in progress.
- ch_ready  in  NUM_CH  per-channel frame-complete request (level).
- ch_dout_enable  out  NUM_CH  one-hot, 1-cycle grant pulse to the channel.
- ch_dout  in  NUM_CH*DW  packed channel data; channel i occupies [i*DW +: DW].
- ch_armfifo_wrreq  in  NUM_CH  per-channel write request.
- ch_armfifo_aclr  in  NUM_CH  per-channel FIFO clear request.
- ch_armfifo_full  out  NUM_CH  per-channel full flag; armfifo_full for the granted channel, 0 for all others.
- armfifo_data  out  DW  data to the ARM FIFO.
- armfifo_wrreq  out  1  write request to the ARM FIFO.
- armfifo_aclr  out  1  clear to the ARM FIFO.
- armfifo_full  in  1  ARM FIFO full flag.
- frame_ready  out  1  level; a frame is in the ARM FIFO.
- frame_ch  out  max(1,$clog2(NUM_CH))  source channel of the frame.
- arm_ack  in  1  ARM has drained the FIFO.
- timeout_err  out  1  1-cycle pulse on watchdog abort.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant=0, cnt=0. All outputs are 0.
- Reset asserted mid-transfer returns to IDLE immediately; the interrupted frame is not notified.
- FSM states: IDLE, GRANT, XFER, NOTIFY.
- IDLE:
  - If enable=1 and ch_ready is non-zero, pick the first ready channel at or after rr_ptr (modulo NUM_CH).
  - Latch that channel into grant and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (1 cycle):
  - Drive ch_dout_enable[grant]=1.
  - Clear cnt.
  - Go to XFER.
- XFER:
  - Routing is combinational (zero-latency mux): armfifo_data=ch_dout[grant], armfifo_wrreq=ch_armfifo_wrreq[grant], armfifo_aclr=ch_armfifo_aclr[grant].
  - The full path is also combinational, so the channel sees full in the same cycle and writes no extra word.
  - Non-granted channels' wrreq/aclr are ignored.
  - cnt increments every cycle.
  - If armfifo_full=1 and ch_armfifo_wrreq[grant]=0: go to NOTIFY, set frame_ready=1 and frame_ch=grant.
  - Else if cnt==TIMEOUT-1: pulse timeout_err, set rr_ptr=grant+1 (mod NUM_CH), go to IDLE without notifying.
- NOTIFY:
  - Hold frame_ready=1 and keep the mux pointed at grant, with wrreq/aclr forced to 0.
  - On arm_ack=1: clear frame_ready, set rr_ptr=grant+1 (mod NUM_CH), go to IDLE.
  - arm_ack outside NOTIFY is ignored.
- Fairness: after any completed or aborted grant, the next search starts at grant+1.
  - Example: with both channels permanently ready, grants alternate 0,1,0,1.
- enable is deasserted during XFER/NOTIFY: the current frame completes normally; no new grant until enable=1.
- ch_ready dropping after the grant is latched does not abort the transfer.
- armfifo_full already 1 on entry to XFER, with no channel write pending: exit to NOTIFY on the first XFER cycle. This is a legal empty transfer.
- Worst-case latency from ch_ready to ch_dout_enable: 2 cycles.

Optional Feature:
- Macro: AVG_ARB_FRAME_HEADER_EN.
- When defined, GRANT expands to three cycles: HDR_CLR, HDR_WR, GRANT.
  - HDR_CLR: arbiter drives armfifo_aclr=1.
  - HDR_WR: arbiter writes one header word with armfifo_wrreq=1; armfifo_data = {frame_ch id in the top bits, frame sequence counter in the low bits}.
  - Frame sequence counter: per-arbiter, increments on every NOTIFY exit, wraps, reset to 0.
  - GRANT: ch_dout_enable pulse as normal.
  - ch_armfifo_aclr[grant] is masked to 0 during XFER so the header is not cleared.
- When undefined: no header is written and the channel's aclr passes through unchanged.

Decomposition:
- Shared package avg_pkg holds:
  - state enum (IDLE, GRANT, XFER, NOTIFY, HDR_CLR, HDR_WR);
  - DW default;
  - header field widths;
  - TIMEOUT default.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority encoder.
  - Inputs: req vector and rr_ptr. Outputs: valid and index.
  - Instanced once.

Test Plan:
- Single channel: ch_ready=01, channel writes 8 words then armfifo_full=1 -> ch_dout_enable=01 pulse 1 cycle after request, 8 armfifo_wrreq pulses with matching data, frame_ready=1 and frame_ch=0 until arm_ack.
- Contention: ch_ready=11 held for 4 frames -> grant order 0,1,0,1, with no overlapping ch_dout_enable.
- Timeout: channel granted but never writes, TIMEOUT=16 -> timeout_err pulses exactly 16 cycles after entering XFER, no frame_ready, next grant goes to ch1.
- Reset mid-XFER after 3 writes -> all outputs 0 the next cycle, rr_ptr=0; a fresh request is granted normally.
- Gating: enable=0 with ch_ready=11 -> no grant; enable=1 while a frame is in NOTIFY -> next grant only after arm_ack.
- Header (AVG_ARB_FRAME_HEADER_EN): second frame from ch1 -> aclr pulse, then header word {1, seq=1}, then channel data.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared types and defaults for the averaging-channel readout arbiter.
// Header field widths apply only when AVG_ARB_FRAME_HEADER_EN is defined.
package avg_pkg;

  localparam int DW_DEF      = 10;
  localparam int TIMEOUT_DEF = 20000;
  // Low bits of the header word carry the frame sequence number; the channel id sits on top.
  localparam int HDR_SEQ_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    XFER,
    NOTIFY,
    HDR_CLR,
    HDR_WR
  } arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/avg_readout_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int c;
    // NOTE: every output gets a default before the loop, otherwise a latch is inferred.
    c     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/avg_readout_arbiter.sv
// Round-robin arbiter sharing one ARM readout FIFO between NUM_CH averaging channels.
// Define AVG_ARB_FRAME_HEADER_EN to prefix each frame with a FIFO clear and a header word.
module avg_readout_arbiter
  import avg_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int DW      = DW_DEF,
  parameter  int TO_W    = 16,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    ch_ready,
  output logic [NUM_CH-1:0]    ch_dout_enable,
  input  logic [NUM_CH*DW-1:0] ch_dout,
  input  logic [NUM_CH-1:0]    ch_armfifo_wrreq,
  input  logic [NUM_CH-1:0]    ch_armfifo_aclr,
  output logic [NUM_CH-1:0]    ch_armfifo_full,
  output logic [DW-1:0]        armfifo_data,
  output logic                 armfifo_wrreq,
  output logic                 armfifo_aclr,
  input  logic                 armfifo_full,
  output logic                 frame_ready,
  output logic [CH_W-1:0]      frame_ch,
  input  logic                 arm_ack,
  output logic                 timeout_err
);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic              pick_valid;
  logic [CH_W-1:0]   pick_idx;
  logic [CH_W-1:0]   grant_next;
  logic [DW-1:0]     grant_dout;
  logic              grant_wr;
  logic              grant_aclr;

`ifdef AVG_ARB_FRAME_HEADER_EN
  logic [HDR_SEQ_W-1:0] seq_q, seq_d;
  logic [DW-1:0]        hdr_word;

  always_comb begin
    hdr_word                   = '0;
    hdr_word[DW-1 -: CH_W]     = grant_q;
    hdr_word[HDR_SEQ_W-1:0]    = seq_q;
  end
`endif

  rr_pick #(.N(NUM_CH), .IW(CH_W)) u_rr_pick (
    .req   (ch_ready),
    .ptr   (rr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign grant_dout  = ch_dout[grant_q*DW +: DW];
  assign grant_wr    = ch_armfifo_wrreq[grant_q];
  assign grant_aclr  = ch_armfifo_aclr[grant_q];
  assign grant_next  = CH_W'(wrap_inc(int'(grant_q), NUM_CH));
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    cnt_d           = cnt_q;
    timeout_err_d   = 1'b0;
    ch_dout_enable  = '0;
    ch_armfifo_full = '0;
    armfifo_data    = '0;
    armfifo_wrreq   = 1'b0;
    armfifo_aclr    = 1'b0;
    frame_ready     = 1'b0;
    frame_ch        = '0;
`ifdef AVG_ARB_FRAME_HEADER_EN
    seq_d           = seq_q;
`endif

    case (state_q)
      IDLE: begin
        if (enable && pick_valid) begin
          grant_d = pick_idx;
`ifdef AVG_ARB_FRAME_HEADER_EN
          state_d = HDR_CLR;
`else
          state_d = GRANT;
`endif
        end
      end
`ifdef AVG_ARB_FRAME_HEADER_EN
      HDR_CLR: begin
        ch_armfifo_full[grant_q] = armfifo_full;
        armfifo_aclr             = 1'b1;
        state_d                  = HDR_WR;
      end
      HDR_WR: begin
        ch_armfifo_full[grant_q] = armfifo_full;
        armfifo_wrreq            = 1'b1;
        armfifo_data             = hdr_word;
        state_d                  = GRANT;
      end
`endif
      GRANT: begin
        ch_dout_enable[grant_q]  = 1'b1;
        ch_armfifo_full[grant_q] = armfifo_full;
        cnt_d                    = '0;
        state_d                  = XFER;
      end
      XFER: begin
        // Full is fed back combinationally so the channel stops in the same cycle.
        ch_armfifo_full[grant_q] = armfifo_full;
        armfifo_data             = grant_dout;
        armfifo_wrreq            = grant_wr;
`ifdef AVG_ARB_FRAME_HEADER_EN
        armfifo_aclr             = 1'b0;
`else
        armfifo_aclr             = grant_aclr;
`endif
        cnt_d                    = cnt_q + 1'b1;
        if (armfifo_full && !grant_wr) begin
          state_d = NOTIFY;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          rr_d          = grant_next;
          state_d       = IDLE;
        end
      end
      NOTIFY: begin
        ch_armfifo_full[grant_q] = armfifo_full;
        armfifo_data             = grant_dout;
        frame_ready              = 1'b1;
        frame_ch                 = grant_q;
        if (arm_ack) begin
          rr_d    = grant_next;
          state_d = IDLE;
`ifdef AVG_ARB_FRAME_HEADER_EN
          seq_d   = seq_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`ifdef AVG_ARB_FRAME_HEADER_EN
      seq_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`ifdef AVG_ARB_FRAME_HEADER_EN
      seq_q         <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_avg_readout_arbiter.sv
// Directed, table-driven bench for avg_readout_arbiter (NUM_CH=2, DW=10, TIMEOUT=16).
// Inputs are driven and outputs sampled in the low half of the clock period.
module tb_avg_readout_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  ch_ready;
  logic [1:0]  ch_dout_enable;
  logic [9:0]  d0, d1;
  logic [1:0]  ch_armfifo_wrreq;
  logic [1:0]  ch_armfifo_aclr;
  logic [1:0]  ch_armfifo_full;
  logic [9:0]  armfifo_data;
  logic        armfifo_wrreq;
  logic        armfifo_aclr;
  logic        armfifo_full;
  logic        frame_ready;
  logic [0:0]  frame_ch;
  logic        arm_ack;
  logic        timeout_err;
  logic [18:0] outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avg_readout_arbiter #(.NUM_CH(2), .DW(10), .TO_W(16), .TIMEOUT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .ch_ready         (ch_ready),
    .ch_dout_enable   (ch_dout_enable),
    .ch_dout          ({d1, d0}),
    .ch_armfifo_wrreq (ch_armfifo_wrreq),
    .ch_armfifo_aclr  (ch_armfifo_aclr),
    .ch_armfifo_full  (ch_armfifo_full),
    .armfifo_data     (armfifo_data),
    .armfifo_wrreq    (armfifo_wrreq),
    .armfifo_aclr     (armfifo_aclr),
    .armfifo_full     (armfifo_full),
    .frame_ready      (frame_ready),
    .frame_ch         (frame_ch),
    .arm_ack          (arm_ack),
    .timeout_err      (timeout_err)
  );

  assign outs = {ch_dout_enable, armfifo_wrreq, armfifo_aclr, armfifo_data,
                 ch_armfifo_full, frame_ready, frame_ch, timeout_err};

  typedef struct {
    logic [1:0]  rdy;
    logic [1:0]  wr;
    logic [1:0]  acl;
    logic        full;
    logic        ack;
    logic [9:0]  d0;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

`ifdef AVG_ARB_FRAME_HEADER_EN
  localparam logic XFER_ACLR = 1'b0;
`else
  localparam logic XFER_ACLR = 1'b1;
`endif

  function automatic logic [18:0] ex(input logic [1:0] de, input logic wr, input logic acl,
                                     input logic [9:0] data, input logic [1:0] chf,
                                     input logic fr, input logic fch);
    return {de, wr, acl, data, chf, fr, fch, 1'b0};
  endfunction

  function automatic vec_t mk(input logic [1:0] rdy, input logic [1:0] wr, input logic [1:0] acl,
                              input logic full, input logic ack, input logic [9:0] dd,
                              input logic [18:0] e);
    vec_t v;
    v.rdy = rdy; v.wr = wr; v.acl = acl; v.full = full; v.ack = ack; v.d0 = dd; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic quiet_inputs();
    ch_armfifo_wrreq = '0;
    ch_armfifo_aclr  = '0;
    armfifo_full     = 1'b0;
    arm_ack          = 1'b0;
    d0               = '0;
    d1               = 10'h3FF;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    ch_ready = '0;
    quiet_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Watch up to 8 windows for a grant pulse; inputs must already request one.
  task automatic wait_grant(output int idx);
    idx = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (ch_dout_enable != 2'b00) begin
        check("grant_onehot", 32'($onehot(ch_dout_enable)), 32'd1);
        idx = (ch_dout_enable == 2'b10) ? 1 : 0;
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: got no ch_dout_enable within 8 cycles, required one");
    end
  endtask

  // Grant, empty transfer ended by full, notify and acknowledge.
  task automatic run_frame(input int exp_ch);
    int idx;
    wait_grant(idx);
    check("grant_ch", 32'(idx), 32'(exp_ch));
    @(negedge clk);
    armfifo_full = 1'b1;
    @(negedge clk);
    armfifo_full = 1'b0;
    #1;
    check("notify_frame", {30'd0, frame_ready, frame_ch}, {30'd0, 1'b1, 1'(exp_ch)});
    arm_ack = 1'b1;
    @(negedge clk);
    arm_ack = 1'b0;
  endtask

  initial begin
    int   idx;
    logic bad;

    // Single-channel frame as a cycle-by-cycle vector table.
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 10'h000, ex(2'b00, 0, 0, 10'h000, 2'b00, 0, 0)));
`ifdef AVG_ARB_FRAME_HEADER_EN
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 10'h000, ex(2'b00, 0, 1, 10'h000, 2'b00, 0, 0)));
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 10'h000, ex(2'b00, 1, 0, 10'h000, 2'b00, 0, 0)));
`endif
    vecs.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 10'h000, ex(2'b01, 0, 0, 10'h000, 2'b00, 0, 0)));
    for (int k = 0; k < 8; k++) begin
      logic [9:0] w;
      w = 10'(10'h100 + k * 3);
      vecs.push_back(mk(2'b00, 2'b01, 2'b00, 1'b0, 1'b0, w, ex(2'b00, 1, 0, w, 2'b00, 0, 0)));
    end
    vecs.push_back(mk(2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 10'h155, ex(2'b00, 0, 0, 10'h155, 2'b00, 0, 0)));
    vecs.push_back(mk(2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 10'h0AA, ex(2'b00, 0, XFER_ACLR, 10'h0AA, 2'b00, 0, 0)));
    vecs.push_back(mk(2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 10'h1FF, ex(2'b00, 1, 0, 10'h1FF, 2'b01, 0, 0)));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 10'h000, ex(2'b00, 0, 0, 10'h000, 2'b01, 0, 0)));
    vecs.push_back(mk(2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 10'h123, ex(2'b00, 0, 0, 10'h123, 2'b01, 1, 0)));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 10'h123, ex(2'b00, 0, 0, 10'h123, 2'b01, 1, 0)));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 10'h000, ex(2'b00, 0, 0, 10'h000, 2'b00, 0, 0)));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 10'h000, ex(2'b00, 0, 0, 10'h000, 2'b00, 0, 0)));
    vecs.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 10'h000, ex(2'b00, 0, 0, 10'h000, 2'b00, 0, 0)));

    // Reset state, with requests present to show they are ignored.
    reset    = 1'b1;
    enable   = 1'b1;
    ch_ready = 2'b11;
    quiet_inputs();
    #2;
    check("reset_outputs", {13'd0, outs}, 32'd0);
    do_reset();

    enable = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk);
      ch_ready         = vecs[i].rdy;
      ch_armfifo_wrreq = vecs[i].wr;
      ch_armfifo_aclr  = vecs[i].acl;
      armfifo_full     = vecs[i].full;
      arm_ack          = vecs[i].ack;
      d0               = vecs[i].d0;
      #1;
      if (outs !== vecs[i].exp)
        $display("FAIL vec[%0d]: got %05h expected %05h", i, outs, vecs[i].exp);
      checks++;
      if (outs !== vecs[i].exp) errors++;
    end

    // Contention: both channels ready for four frames.
    do_reset();
    @(negedge clk);
    enable   = 1'b1;
    ch_ready = 2'b11;
    for (int f = 0; f < 4; f++) run_frame(f % 2);

    // Watchdog: channel 0 granted and never writes.
    do_reset();
    @(negedge clk);
    enable   = 1'b1;
    ch_ready = 2'b01;
    wait_grant(idx);
    check("to_grant_ch", 32'(idx), 32'd0);
    ch_ready = 2'b00;
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      if (timeout_err || frame_ready) bad = 1'b1;
    end
    check("to_not_early", {31'd0, bad}, 32'd0);
    @(negedge clk);
    ch_ready = 2'b11;
    #1;
    check("to_pulse", {30'd0, timeout_err, frame_ready}, 32'b10);
    @(negedge clk);
    #1;
    check("to_one_cycle", {31'd0, timeout_err}, 32'd0);
    // The pick made in the pulse cycle must already be channel 1.
    check("to_next_grant", {30'd0, ch_dout_enable}, 32'b10);

    // Reset in the middle of a channel 1 transfer.
    do_reset();
    @(negedge clk);
    enable   = 1'b1;
    ch_ready = 2'b01;
    run_frame(0);
    ch_ready = 2'b10;
    wait_grant(idx);
    check("rst_grant_ch", 32'(idx), 32'd1);
    ch_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ch_armfifo_wrreq = 2'b10;
      d1 = 10'(10'h2A0 + k);
      #1;
      check("rst_write", {21'd0, armfifo_wrreq, armfifo_data}, {21'd0, 1'b1, 10'(10'h2A0 + k)});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_async_outputs", {13'd0, outs}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet_inputs();
    enable   = 1'b1;
    ch_ready = 2'b11;
    #1;
    check("rst_idle_outputs", {13'd0, outs}, 32'd0);
    wait_grant(idx);
    check("rst_rr_zero", 32'(idx), 32'd0);

    // Enable gating and no grant while a frame waits for acknowledge.
    do_reset();
    @(negedge clk);
    enable   = 1'b0;
    ch_ready = 2'b11;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (ch_dout_enable != 2'b00) bad = 1'b1;
    end
    check("gate_no_grant", {31'd0, bad}, 32'd0);
    enable = 1'b1;
    wait_grant(idx);
    check("gate_grant_ch", 32'(idx), 32'd0);
    @(negedge clk);
    armfifo_full = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      armfifo_full = 1'b0;
      #1;
      if (ch_dout_enable != 2'b00 || !frame_ready) bad = 1'b1;
      if (k == 2) arm_ack = 1'b1;
    end
    check("gate_hold_notify", {31'd0, bad}, 32'd0);
    @(negedge clk);
    arm_ack = 1'b0;
    #1;
    check("gate_ack_clears", {31'd0, frame_ready}, 32'd0);
    wait_grant(idx);
    check("gate_next_ch", 32'(idx), 32'd1);

`ifdef AVG_ARB_FRAME_HEADER_EN
    // Second frame, from channel 1: clear, header {ch=1, seq=1}, then channel data.
    do_reset();
    @(negedge clk);
    enable   = 1'b1;
    ch_ready = 2'b01;
    run_frame(0);
    ch_ready = 2'b10;
    @(negedge clk);
    #1;
    check("hdr_clr", {30'd0, armfifo_aclr, armfifo_wrreq}, 32'b10);
    @(negedge clk);
    #1;
    check("hdr_word", {21'd0, armfifo_wrreq, armfifo_data}, {21'd0, 1'b1, 10'h201});
    @(negedge clk);
    #1;
    check("hdr_grant", {30'd0, ch_dout_enable}, 32'b10);
    @(negedge clk);
    ch_armfifo_wrreq = 2'b10;
    ch_armfifo_aclr  = 2'b10;
    d1 = 10'h077;
    #1;
    check("hdr_data", {20'd0, armfifo_wrreq, armfifo_aclr, armfifo_data}, {20'd0, 2'b10, 10'h077});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 ns, required completion");
    $fatal(1);
  end

endmodule
